// File: rtl/picoregs_ctrl.sv
// Sequencer for the 32x32 dual-port BRAM register file: zero-fill after reset,
// write-over-read arbitration, and x0 hard-wired to zero on both read operands.
module picoregs_ctrl #(
  parameter int ADDR_W         = 5,
  parameter int DATA_W         = 32,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_rs1,
  input  logic [ADDR_W-1:0] rd_rs2,
  output logic              rd_ack,
  output logic [DATA_W-1:0] rd_data1,
  output logic [DATA_W-1:0] rd_data2,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ack,
  output logic              busy,
  output logic              ram_cea,
  output logic              ram_ceb,
  output logic              ram_ocea,
  output logic              ram_oceb,
  output logic              ram_wrea,
  output logic              ram_wreb,
  output logic              ram_reseta,
  output logic              ram_resetb,
  output logic [ADDR_W-1:0] ram_ada,
  output logic [ADDR_W-1:0] ram_adb,
  output logic [DATA_W-1:0] ram_dina,
  output logic [DATA_W-1:0] ram_dinb,
  input  logic [DATA_W-1:0] ram_douta,
  input  logic [DATA_W-1:0] ram_doutb
);

  localparam int CNT_W = ADDR_W - 1;

  typedef enum logic [1:0] {S_INIT, S_IDLE, S_RWAIT, S_WACK} state_t;

  localparam state_t RST_STATE = (CLEAR_ON_RESET != 0) ? S_INIT : S_IDLE;
  localparam logic   RST_BUSY  = (CLEAR_ON_RESET != 0);

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                busy_q, busy_d;
  logic                rd_ack_q, rd_ack_d;
  logic                wr_ack_q, wr_ack_d;
  logic [ADDR_W-1:0]   rs1_q, rs1_d;
  logic [ADDR_W-1:0]   rs2_q, rs2_d;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    rd_ack_d = 1'b0;
    wr_ack_d = 1'b0;
    rs1_d    = rs1_q;
    rs2_d    = rs2_q;
    ram_cea  = 1'b0;
    ram_ceb  = 1'b0;
    ram_wrea = 1'b0;
    ram_wreb = 1'b0;
    ram_ada  = '0;
    ram_adb  = '0;
    ram_dina = '0;
    ram_dinb = '0;
    case (state_q)
      S_INIT: begin
        // Two registers per cycle: even index on port A, odd on port B.
        ram_cea  = 1'b1;
        ram_ceb  = 1'b1;
        ram_wrea = 1'b1;
        ram_wreb = 1'b1;
        ram_ada  = {cnt_q, 1'b0};
        ram_adb  = {cnt_q, 1'b1};
        cnt_d    = cnt_q + 1'b1;
        if (&cnt_q) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end
      end
      S_IDLE: begin
        if (wr_req) begin
          if (wr_addr != '0) begin
            ram_cea  = 1'b1;
            ram_wrea = 1'b1;
            ram_ada  = wr_addr;
            ram_dina = wr_data;
          end
          state_d  = S_WACK;
          wr_ack_d = 1'b1;
        end else if (rd_req) begin
          ram_cea  = 1'b1;
          ram_ceb  = 1'b1;
          ram_ada  = rd_rs1;
          ram_adb  = rd_rs2;
          rs1_d    = rd_rs1;
          rs2_d    = rd_rs2;
          state_d  = S_RWAIT;
          rd_ack_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Keep the RAM quiet while reset is held, even though the state sits in INIT.
    if (!resetn) begin
      ram_cea  = 1'b0;
      ram_ceb  = 1'b0;
      ram_wrea = 1'b0;
      ram_wreb = 1'b0;
      ram_ada  = '0;
      ram_adb  = '0;
      ram_dina = '0;
      ram_dinb = '0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= RST_STATE;
      cnt_q    <= '0;
      busy_q   <= RST_BUSY;
      rd_ack_q <= 1'b0;
      wr_ack_q <= 1'b0;
      rs1_q    <= '0;
      rs2_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      rd_ack_q <= rd_ack_d;
      wr_ack_q <= wr_ack_d;
      rs1_q    <= rs1_d;
      rs2_q    <= rs2_d;
    end
  end

  assign busy       = busy_q;
  assign rd_ack     = rd_ack_q;
  assign wr_ack     = wr_ack_q;
  assign ram_ocea   = 1'b1;
  assign ram_oceb   = 1'b1;
  assign ram_reseta = 1'b0;
  assign ram_resetb = 1'b0;

  // x0 reads as zero regardless of RAM contents; outputs masked outside the ack cycle.
  assign rd_data1 = (rd_ack_q && rs1_q != '0) ? ram_douta : '0;
  assign rd_data2 = (rd_ack_q && rs2_q != '0) ? ram_doutb : '0;

endmodule

// File: tb/tb_picoregs_ctrl.sv
// Directed bench for picoregs_ctrl: behavioural dual-port RAM, vector table of
// writes/reads, plus hand sequences for same-cycle requests and mid-read reset.
module tb_picoregs_ctrl;
  localparam int AW = 5;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          rd_req = 1'b0, wr_req = 1'b0;
  logic [AW-1:0] rd_rs1 = '0, rd_rs2 = '0, wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          rd_ack, wr_ack, busy;
  logic [DW-1:0] rd_data1, rd_data2;
  logic          ram_cea, ram_ceb, ram_ocea, ram_oceb, ram_wrea, ram_wreb;
  logic          ram_reseta, ram_resetb;
  logic [AW-1:0] ram_ada, ram_adb;
  logic [DW-1:0] ram_dina, ram_dinb;
  logic [DW-1:0] ram_douta, ram_doutb;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  picoregs_ctrl #(.ADDR_W(AW), .DATA_W(DW), .CLEAR_ON_RESET(1)) dut (
    .clk(clk), .resetn(resetn),
    .rd_req(rd_req), .rd_rs1(rd_rs1), .rd_rs2(rd_rs2), .rd_ack(rd_ack),
    .rd_data1(rd_data1), .rd_data2(rd_data2),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
    .busy(busy),
    .ram_cea(ram_cea), .ram_ceb(ram_ceb), .ram_ocea(ram_ocea), .ram_oceb(ram_oceb),
    .ram_wrea(ram_wrea), .ram_wreb(ram_wreb), .ram_reseta(ram_reseta), .ram_resetb(ram_resetb),
    .ram_ada(ram_ada), .ram_adb(ram_adb), .ram_dina(ram_dina), .ram_dinb(ram_dinb),
    .ram_douta(ram_douta), .ram_doutb(ram_doutb)
  );

  // RAM model; stale nonzero contents are loaded while reset is held.
  logic [DW-1:0] mem [32];
  always @(posedge clk) begin
    if (!resetn) begin
      for (int i = 0; i < 32; i++) mem[i] <= 32'hBAD0_0000 | i;
    end else begin
      if (ram_cea) begin
        if (ram_wrea) mem[ram_ada] <= ram_dina;
        ram_douta <= mem[ram_ada];
      end
      if (ram_ceb) begin
        if (ram_wreb) mem[ram_adb] <= ram_dinb;
        ram_doutb <= mem[ram_adb];
      end
    end
  end

  int clear_hits [32];
  int wr_events;
  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < 32; i++) clear_hits[i] <= 0;
      wr_events <= 0;
    end else begin
      if (busy && ram_cea && ram_wrea && ram_dina == '0) clear_hits[ram_ada] <= clear_hits[ram_ada] + 1;
      if (busy && ram_ceb && ram_wreb && ram_dinb == '0) clear_hits[ram_adb] <= clear_hits[ram_adb] + 1;
      if ((ram_cea && ram_wrea) || (ram_ceb && ram_wreb)) wr_events <= wr_events + 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Counts busy cycles from a reset release at a negedge; also flags any ack while busy.
  task automatic run_clear(input string tag);
    int n = 0;
    int acks = 0;
    int bad = 0;
    while (busy && n < 100) begin
      n++;
      if (rd_ack || wr_ack) acks++;
      @(negedge clk);
    end
    chk({tag, "_busy_cycles"}, 32'(n), 32'd16);
    chk({tag, "_ack_while_busy"}, 32'(acks), 32'd0);
    for (int i = 0; i < 32; i++) if (clear_hits[i] != 1) bad++;
    chk({tag, "_clear_hits_bad"}, 32'(bad), 32'd0);
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input bit exp_ram);
    int lat = 0;
    int w0;
    @(posedge clk); #1;
    wr_req = 1'b1; wr_addr = a; wr_data = d; w0 = wr_events;
    @(negedge clk);
    while (!wr_ack && lat < 20) begin lat++; @(negedge clk); end
    chk("wr_latency", 32'(lat), 32'd1);
    chk("wr_ram_writes", 32'(wr_events - w0), exp_ram ? 32'd1 : 32'd0);
    @(posedge clk); #1;
    wr_req = 1'b0;
    @(negedge clk);
    chk("wr_ack_pulse", {31'd0, wr_ack}, 32'd0);
  endtask

  task automatic do_read(input logic [AW-1:0] r1, input logic [AW-1:0] r2,
                         input logic [DW-1:0] e1, input logic [DW-1:0] e2);
    int lat = 0;
    @(posedge clk); #1;
    rd_req = 1'b1; rd_rs1 = r1; rd_rs2 = r2;
    @(negedge clk);
    while (!rd_ack && lat < 20) begin lat++; @(negedge clk); end
    chk("rd_latency", 32'(lat), 32'd1);
    chk("rd_data1", rd_data1, e1);
    chk("rd_data2", rd_data2, e2);
    @(posedge clk); #1;
    rd_req = 1'b0;
    @(negedge clk);
    chk("rd_ack_pulse", {31'd0, rd_ack}, 32'd0);
    chk("rd_data1_masked", rd_data1, 32'd0);
  endtask

  typedef struct {
    bit            is_wr;
    logic [AW-1:0] a;
    logic [AW-1:0] b;
    logic [DW-1:0] d;
    logic [DW-1:0] e1;
    logic [DW-1:0] e2;
  } vec_t;

  vec_t vec [9];

  initial begin
    int lat;
    vec[0] = '{1'b0, 5'd7,  5'd31, 32'h0,         32'h0,         32'h0};
    vec[1] = '{1'b1, 5'd5,  5'd0,  32'hDEADBEEF,  32'h0,         32'h0};
    vec[2] = '{1'b0, 5'd5,  5'd0,  32'h0,         32'hDEADBEEF,  32'h0};
    vec[3] = '{1'b1, 5'd0,  5'd0,  32'h12345678,  32'h0,         32'h0};
    vec[4] = '{1'b0, 5'd0,  5'd5,  32'h0,         32'h0,         32'hDEADBEEF};
    vec[5] = '{1'b1, 5'd31, 5'd0,  32'h00000001,  32'h0,         32'h0};
    vec[6] = '{1'b0, 5'd31, 5'd31, 32'h0,         32'h1,         32'h1};
    vec[7] = '{1'b1, 5'd5,  5'd0,  32'hCAFEF00D,  32'h0,         32'h0};
    vec[8] = '{1'b0, 5'd5,  5'd31, 32'h0,         32'hCAFEF00D,  32'h1};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd1);
    chk("rst_rd_ack", {31'd0, rd_ack}, 32'd0);
    chk("rst_wr_ack", {31'd0, wr_ack}, 32'd0);
    chk("rst_ram_en", {28'd0, ram_cea, ram_ceb, ram_wrea, ram_wreb}, 32'd0);
    chk("rst_ram_ad", {22'd0, ram_ada, ram_adb}, 32'd0);
    chk("rst_consts", {28'd0, ram_ocea, ram_oceb, ram_reseta, ram_resetb}, 32'hC);

    resetn = 1'b1;
    run_clear("init");

    for (int i = 0; i < 9; i++) begin
      if (vec[i].is_wr) do_write(vec[i].a, vec[i].d, vec[i].a != '0);
      else              do_read(vec[i].a, vec[i].b, vec[i].e1, vec[i].e2);
    end

    // Write and read raised together: write first, read sees new value.
    @(posedge clk); #1;
    wr_req = 1'b1; wr_addr = 5'd9; wr_data = 32'hA5A5A5A5;
    rd_req = 1'b1; rd_rs1 = 5'd9; rd_rs2 = 5'd9;
    lat = 0;
    @(negedge clk);
    while (!wr_ack && lat < 20) begin
      if (rd_ack) lat = 100;
      lat++;
      @(negedge clk);
    end
    chk("pair_wr_latency", 32'(lat), 32'd1);
    chk("pair_rd_not_first", {31'd0, rd_ack}, 32'd0);
    @(posedge clk); #1;
    wr_req = 1'b0;
    lat = 1;
    @(negedge clk);
    while (!rd_ack && lat < 20) begin lat++; @(negedge clk); end
    chk("pair_rd_after_wr", 32'(lat), 32'd2);
    chk("pair_rd_data1", rd_data1, 32'hA5A5A5A5);
    chk("pair_rd_data2", rd_data2, 32'hA5A5A5A5);
    @(posedge clk); #1;
    rd_req = 1'b0;

    // Reset in the read-ack cycle, with the read held through the clear.
    @(posedge clk); #1;
    rd_req = 1'b1; rd_rs1 = 5'd5; rd_rs2 = 5'd0;
    lat = 0;
    @(negedge clk);
    while (!rd_ack && lat < 20) begin lat++; @(negedge clk); end
    chk("rw_rd_ack_seen", 32'(lat), 32'd1);
    resetn = 1'b0;
    #1;
    chk("rw_rd_ack_dropped", {31'd0, rd_ack}, 32'd0);
    chk("rw_busy", {31'd0, busy}, 32'd1);
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    run_clear("rerun");
    chk("held_rd_no_ack_first_idle", {31'd0, rd_ack}, 32'd0);
    @(negedge clk);
    chk("held_rd_ack", {31'd0, rd_ack}, 32'd1);
    chk("held_rd_x5_cleared", rd_data1, 32'd0);
    chk("held_rd_x0", rd_data2, 32'd0);
    @(posedge clk); #1;
    rd_req = 1'b0;
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
